// File: rtl/bbox_msg_sched_if.sv
// bbox_msg_sched_if: write side of the CPU-bound MSG_FIFO.
// The scheduler (master) drives the write strobe and data word and
// reads back the registered fill level; the FIFO (slave) does the reverse.
interface bbox_msg_sched_if;
    logic        fifo_wrreq;
    logic [31:0] fifo_data;
    logic [7:0]  fifo_usedw;

    modport master (
        output fifo_wrreq,
        output fifo_data,
        input  fifo_usedw
    );

    modport slave (
        input  fifo_wrreq,
        input  fifo_data,
        output fifo_usedw
    );
endinterface

// File: rtl/bbox_msg_sched.sv
// bbox_msg_sched: round-robin scheduler that, once every MSG_INTERVAL frames,
// snapshots the per-colour bounding-box trackers and writes one 3-word message
// (id, top-left, bottom-right) per non-empty box into the shared MSG_FIFO.
// Messages that do not fit, and epochs that arrive while busy, are counted in
// a saturating drop counter.
// Optional feature: define BBOX_MSG_EOF_MARKER_EN to append an "EOF" word
// after every epoch (EOFM state).
module bbox_msg_sched #(
    parameter int N_REQ           = 4,
    parameter int MESSAGE_BUF_MAX = 256,
    parameter int MSG_INTERVAL    = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_end,
    input  logic [N_REQ-1:0]      bb_found,
    input  logic [N_REQ*44-1:0]   bb_coords,
    input  logic [N_REQ*24-1:0]   bb_ids,
    bbox_msg_sched_if.master      msg_fifo,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    localparam int         IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int         MSG_LIM   = MESSAGE_BUF_MAX - 3;
    localparam logic [7:0] CNT_RELOAD = 8'(MSG_INTERVAL - 1);
`ifdef BBOX_MSG_EOF_MARKER_EN
    localparam int          EOF_LIM  = MESSAGE_BUF_MAX - 1;
    localparam logic [31:0] EOF_WORD = 32'h00454F46;
`endif

`ifdef BBOX_MSG_EOF_MARKER_EN
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_TL, S_BR, S_EOFM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_TL, S_BR} state_t;
`endif

    // Number of set bits in the pending mask (at most 16).
    function automatic logic [4:0] popcnt(input logic [N_REQ-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

    // 8-bit add that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {4'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_frame_cnt;
    logic [N_REQ-1:0]      r_pending;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_sel;
    logic [7:0]            r_drop_cnt;
    logic                  r_wrreq;
    logic [31:0]           r_data;
    logic [N_REQ*44-1:0]   r_coords;
    logic [N_REQ*24-1:0]   r_ids;

    logic                  w_due;
    logic                  w_start;
    logic                  w_skip;
    logic                  w_found;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W-1:0]      w_g;
    logic [43:0]           w_box;
    logic [23:0]           w_id;
    logic                  w_space;
    logic                  w_wr_nxt;
    logic [31:0]           w_data_nxt;
    logic [N_REQ-1:0]      w_clr_mask;
    logic                  w_drop_all;
    logic                  w_rr_upd;
    logic [IDX_W-1:0]      w_rr_nxt;
    logic [4:0]            w_drop_inc;

    assign w_due   = frame_end && (r_frame_cnt == 8'd0);
    assign w_start = w_due && (r_state == S_IDLE);
    assign w_skip  = w_due && (r_state != S_IDLE);
    assign w_space = int'(msg_fifo.fifo_usedw) < MSG_LIM;

    // Cyclic search for the first pending tracker at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && r_pending[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    // In SCAN the message word comes from the freshly selected tracker, afterwards from the held one.
    assign w_g   = (r_state == S_SCAN) ? w_sel : r_sel;
    assign w_box = r_coords[int'(w_g)*44 +: 44];
    assign w_id  = r_ids[int'(w_g)*24 +: 24];

    // Next-state logic plus the values to be registered onto the FIFO port.
    always_comb begin
        w_next_state = r_state;
        w_wr_nxt     = 1'b0;
        w_data_nxt   = r_data;
        w_clr_mask   = '0;
        w_drop_all   = 1'b0;
        w_rr_upd     = 1'b0;
        w_rr_nxt     = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_due) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_found && w_space) begin
                    w_next_state = S_HDR;
                    w_wr_nxt     = 1'b1;
                    w_data_nxt   = {8'h00, w_id};
                end else begin
                    w_drop_all = w_found;
`ifdef BBOX_MSG_EOF_MARKER_EN
                    w_next_state = S_EOFM;
                    if (int'(msg_fifo.fifo_usedw) < EOF_LIM) begin
                        w_wr_nxt   = 1'b1;
                        w_data_nxt = EOF_WORD;
                    end
`else
                    w_next_state = S_IDLE;
`endif
                end
            end
            S_HDR: begin
                w_next_state = S_TL;
                w_wr_nxt     = 1'b1;
                w_data_nxt   = {5'b0, w_box[43:33], 5'b0, w_box[32:22]};
            end
            S_TL: begin
                w_next_state = S_BR;
                w_wr_nxt     = 1'b1;
                w_data_nxt   = {5'b0, w_box[21:11], 5'b0, w_box[10:0]};
            end
            S_BR: begin
                w_next_state       = S_SCAN;
                w_clr_mask[r_sel]  = 1'b1;
                w_rr_upd           = 1'b1;
                w_rr_nxt           = (int'(r_sel) == N_REQ - 1) ? '0 : r_sel + 1'b1;
            end
`ifdef BBOX_MSG_EOF_MARKER_EN
            S_EOFM: begin
                w_next_state = S_IDLE;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_drop_inc = (w_drop_all ? popcnt(r_pending) : 5'd0) + {4'b0, w_skip};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control state: frame counter, pending mask, fairness pointer, drop counter, FIFO port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_cnt <= 8'd0;
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_drop_cnt  <= 8'd0;
            r_wrreq     <= 1'b0;
            r_data      <= 32'd0;
        end else begin
            if (frame_end) begin
                r_frame_cnt <= (r_frame_cnt == 8'd0) ? CNT_RELOAD : r_frame_cnt - 8'd1;
            end
            if (w_start) begin
                r_pending <= bb_found;
            end else if (w_drop_all) begin
                r_pending <= '0;
            end else begin
                r_pending <= r_pending & ~w_clr_mask;
            end
            if (w_rr_upd) begin
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_drop_all || w_skip) begin
                r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
            end
            r_wrreq <= w_wr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Epoch snapshot and selected-tracker hold; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_coords <= bb_coords;
            r_ids    <= bb_ids;
        end
        if (r_state == S_SCAN) begin
            r_sel <= w_sel;
        end
    end

    assign msg_fifo.fifo_wrreq = r_wrreq;
    assign msg_fifo.fifo_data  = r_data;
    assign busy                = (r_state != S_IDLE);
    assign drop_count          = r_drop_cnt;

endmodule

// File: tb/tb_bbox_msg_sched.sv
// tb_bbox_msg_sched: directed bench for bbox_msg_sched with a small FIFO
// fill-level model and a log of every word written.
module tb_bbox_msg_sched;

    localparam int N_REQ = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                frame_end;
    logic [N_REQ-1:0]    bb_found;
    logic [N_REQ*44-1:0] bb_coords;
    logic [N_REQ*24-1:0] bb_ids;
    logic                busy;
    logic [7:0]          drop_count;

    bbox_msg_sched_if fif();

    bbox_msg_sched #(
        .N_REQ           (N_REQ),
        .MESSAGE_BUF_MAX (256),
        .MSG_INTERVAL    (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_end  (frame_end),
        .bb_found   (bb_found),
        .bb_coords  (bb_coords),
        .bb_ids     (bb_ids),
        .msg_fifo   (fif),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // FIFO model: registered fill level = preset base + words written since last clear.
    int          base_fill = 0;
    logic        fifo_clear = 1'b0;
    int          wcnt = 0;
    int          wr_n = 0;
    logic [31:0] wlog [0:1023];

    always @(posedge clk) begin
        if (fif.fifo_wrreq) begin
            wlog[wr_n] <= fif.fifo_data;
            wr_n       <= wr_n + 1;
        end
        if (fifo_clear) wcnt <= 0;
        else if (fif.fifo_wrreq) wcnt <= wcnt + 1;
    end

    assign fif.fifo_usedw = (base_fill + wcnt > 255) ? 8'd255 : 8'(base_fill + wcnt);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic skip_frames(input int n);
        for (int i = 0; i < n; i++) begin
            pulse();
            tick();
        end
    endtask

    task automatic set_fill(input int b);
        base_fill  = b;
        fifo_clear = 1'b1;
        tick();
        fifo_clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [43:0] box(input int x0, input int y0, input int x1, input int y1);
        return {11'(x0), 11'(y0), 11'(x1), 11'(y1)};
    endfunction

    int s;

    initial begin
        reset_n   = 1'b0;
        frame_end = 1'b0;
        bb_found  = '0;
        bb_coords[0*44 +: 44] = box(10, 20, 30, 40);
        bb_coords[1*44 +: 44] = box(1, 2, 3, 4);
        bb_coords[2*44 +: 44] = box(100, 5, 120, 9);
        bb_coords[3*44 +: 44] = box(2047, 0, 0, 2047);
        bb_ids[0*24 +: 24] = 24'h524242;   // "RBB"
        bb_ids[1*24 +: 24] = 24'h474242;   // "GBB"
        bb_ids[2*24 +: 24] = 24'h424242;   // "BBB"
        bb_ids[3*24 +: 24] = 24'h594242;   // "YBB"

        // Reset state
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_wrreq", {31'b0, fif.fifo_wrreq}, 32'd0);
        chk("rst_data",  fif.fifo_data, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_drop",  {24'b0, drop_count}, 32'd0);

        // Basic epoch: trackers 0 and 2, cycle-exact
        set_fill(0);
        bb_found = 4'b0101;
        pulse();                                                     // now t+1
        chk("basic_busy_t1",  {31'b0, busy}, 32'd1);
        chk("basic_wr_t1",    {31'b0, fif.fifo_wrreq}, 32'd0);
        tick(); chk("basic_wr_t2", {31'b0, fif.fifo_wrreq}, 32'd1);
                chk("basic_d_t2",  fif.fifo_data, 32'h00524242);
        tick(); chk("basic_d_t3",  fif.fifo_data, 32'h000A0014);
        tick(); chk("basic_d_t4",  fif.fifo_data, 32'h001E0028);
        tick(); chk("basic_wr_t5", {31'b0, fif.fifo_wrreq}, 32'd0);
        tick(); chk("basic_d_t6",  fif.fifo_data, 32'h00424242);
        tick(); chk("basic_d_t7",  fif.fifo_data, 32'h00640005);
        tick(); chk("basic_d_t8",  fif.fifo_data, 32'h00780009);
        tick(); chk("basic_busy_t9", {31'b0, busy}, 32'd1);
                chk("basic_wr_t9",   {31'b0, fif.fifo_wrreq}, 32'd0);
        tick(); chk("basic_busy_t10", {31'b0, busy}, 32'd0);
        chk("basic_drop", {24'b0, drop_count}, 32'd0);

        // Interval: 13 pulses, epochs only on 1, 7, 13
        do_reset();
        bb_found = 4'b0000;
        for (int p = 1; p <= 13; p++) begin
            pulse();
            chk($sformatf("interval_p%0d", p), {31'b0, busy},
                (p == 1 || p == 7 || p == 13) ? 32'd1 : 32'd0);
            tick();
            tick();
        end

        // Round-robin carry: room for exactly two messages
        do_reset();
        bb_found = 4'b1111;
        set_fill(247);
        s = wr_n;
        pulse();
        wait_idle("rr1_idle");
        chk("rr1_words", 32'(wr_n - s), 32'd6);
        chk("rr1_hdr0",  wlog[s],     32'h00524242);
        chk("rr1_hdr1",  wlog[s + 3], 32'h00474242);
        chk("rr1_drop",  {24'b0, drop_count}, 32'd2);
        set_fill(0);
        skip_frames(5);
        s = wr_n;
        pulse();
        wait_idle("rr2_idle");
        chk("rr2_words", 32'(wr_n - s), 32'd12);
        chk("rr2_hdr_a", wlog[s],     32'h00424242);
        chk("rr2_hdr_b", wlog[s + 3], 32'h00594242);
        chk("rr2_tl_b",  wlog[s + 4], 32'h07FF0000);
        chk("rr2_br_b",  wlog[s + 5], 32'h000007FF);
        chk("rr2_hdr_c", wlog[s + 6], 32'h00524242);
        chk("rr2_hdr_d", wlog[s + 9], 32'h00474242);
        chk("rr2_drop",  {24'b0, drop_count}, 32'd2);

        // FIFO full at SCAN with three pending
        bb_found = 4'b0111;
        set_fill(253);
        skip_frames(5);
        s = wr_n;
        pulse();
        chk("full_busy_scan", {31'b0, busy}, 32'd1);
        tick();
        chk("full_busy_after", {31'b0, busy}, 32'd0);
        chk("full_drop",  {24'b0, drop_count}, 32'd5);
        chk("full_words", 32'(wr_n - s), 32'd0);

        // Overlap: epoch due while busy is skipped and counted
        do_reset();
        bb_found = 4'b1111;
        set_fill(0);
        s = wr_n;
        frame_end = 1'b1;
        repeat (7) tick();
        frame_end = 1'b0;
        chk("overlap_drop", {24'b0, drop_count}, 32'd1);
        wait_idle("overlap_idle");
        chk("overlap_words", 32'(wr_n - s), 32'd12);
        chk("overlap_hdr0",  wlog[s], 32'h00524242);

        // Saturation: full FIFO, four dropped per epoch
        set_fill(253);
        frame_end = 1'b1;
        repeat (372) tick();
        frame_end = 1'b0;
        tick();
        tick();
        chk("sat_pre", {24'b0, drop_count}, 32'd249);
        frame_end = 1'b1;
        repeat (18) tick();
        frame_end = 1'b0;
        tick();
        tick();
        chk("sat_hold", {24'b0, drop_count}, 32'd255);

        // Reset during TL of an epoch that started at tracker 3
        set_fill(0);
        bb_found = 4'b0101;
        skip_frames(5);
        pulse();
        wait_idle("mid_pre_idle");
        bb_found = 4'b1111;
        skip_frames(5);
        pulse();
        tick(); chk("mid_hdr3", fif.fifo_data, 32'h00594242);
        tick(); chk("mid_tl3",  fif.fifo_data, 32'h07FF0000);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_wrreq", {31'b0, fif.fifo_wrreq}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy}, 32'd0);
        chk("mid_rst_drop",  {24'b0, drop_count}, 32'd0);
        pulse();
        chk("mid_new_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("mid_new_wr",  {31'b0, fif.fifo_wrreq}, 32'd1);
        chk("mid_new_hdr", fif.fifo_data, 32'h00524242);
        wait_idle("mid_new_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bbox_msg_sched.md
# bbox_msg_sched

- Round-robin scheduler that shares the single CPU-bound message FIFO between up to `N_REQ` per-colour bounding-box trackers in the vision pipeline.
- Once every `MSG_INTERVAL` video frames it snapshots every tracker's box and writes one 3-word message per non-empty box into the FIFO.
- Before each message it checks FIFO space, and it counts messages it has to drop.
- It sits between the per-colour min/max trackers and the MSG_FIFO write port; the Avalon-MM read side is unchanged.

## Interface

Parameters:
- `N_REQ`, 4, number of colour trackers (1..16).
- `MESSAGE_BUF_MAX`, 256, FIFO depth in words.
- `MSG_INTERVAL`, 6, frames per reporting epoch (≥1).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `frame_end` in 1: one-cycle pulse on the last valid pixel of a video packet.
- `bb_found` in `N_REQ`: bit i high when tracker i saw ≥1 pixel this frame.
- `bb_coords` in `N_REQ*44`: tracker i occupies `[44i+43:44i]` = {x_min, y_min, x_max, y_max}, 11 bits each.
- `bb_ids` in `N_REQ*24`: tracker i's 24-bit ASCII tag (e.g. "RBB") at `[24i+23:24i]`.
- `fifo_usedw` in 8: FIFO fill level; registered, reflects a write one cycle after `fifo_wrreq`.
- `fifo_wrreq` out 1: FIFO write strobe.
- `fifo_data` out 32: FIFO write word.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `drop_count` out 8: saturating count of dropped messages.

## Operation

- **Frame counter** (`frame_cnt`, 8 bits): decrements on each `frame_end`.
  - An epoch is due when `frame_end` arrives with `frame_cnt==0`.
  - When due, the counter reloads to `MSG_INTERVAL-1`.
- **Epoch start** (FSM in IDLE when due):
  - Latch `bb_found` into `pending[N_REQ-1:0]`.
  - Latch `bb_coords` and `bb_ids` into shadow registers.
  - Go to SCAN.
- **Epoch due while busy**: the epoch is skipped, the counter still reloads, and `drop_count` increments by 1.
- **FSM states**: IDLE, SCAN, HDR, TL, BR (plus EOFM under the macro).
- **SCAN**:
  - Select the first set `pending` bit at or after `rr_ptr`, searching cyclically; the selected index is `g`.
  - No pending bit set → IDLE.
  - `fifo_usedw < MESSAGE_BUF_MAX-3` → HDR.
  - Otherwise → drop every remaining pending message: `drop_count += popcount(pending)` (saturating at 255), clear `pending`, go to IDLE.
- **HDR**: write `{8'h00, id[g]}`.
- **TL**: write `{5'b0, x_min[g], 5'b0, y_min[g]}`.
- **BR**:
  - Write `{5'b0, x_max[g], 5'b0, y_max[g]}`.
  - Clear `pending[g]`.
  - Set `rr_ptr <= (g+1) mod N_REQ`.
  - Go to SCAN.
- **Fairness**: `rr_ptr` persists across epochs. The tracker served first in an epoch is the one after the last tracker served.
- **Snapshot isolation**: shadow registers change only at epoch start. Tracker updates during an epoch do not affect messages in flight.
- **Reset values**:
  - Outputs: `fifo_wrreq=0`, `fifo_data=0`, `busy=0`, `drop_count=0`.
  - Internal: `frame_cnt=0` (first frame is reported), `rr_ptr=0`, `pending=0`, state IDLE.
- **Reset mid-message**: abandons the message; a partial message may remain in the FIFO. The CPU flushes via the status register.

## Timing

- **Start latency**: `frame_end` at cycle t (epoch due, FSM idle) → SCAN at t+1 → first `fifo_wrreq` at t+2.
- **Per-message cost**:
  - Each message is 3 consecutive `fifo_wrreq` cycles (HDR, TL, BR) plus 1 SCAN cycle.
  - One full epoch with k messages takes 4k+1 cycles after t.
- **Space check**: the SCAN after BR sees a `fifo_usedw` that already includes the BR word, because `usedw` is registered.
- **Output registering**: `fifo_wrreq` and `fifo_data` are registered and asserted only in HDR/TL/BR (and EOFM).
  - `fifo_data` holds its last value otherwise.
- **Busy**: `busy` asserts the cycle after epoch start and deasserts on the cycle IDLE is re-entered.

## Configuration

- **`BBOX_MSG_EOF_MARKER_EN` defined**:
  - When SCAN finds no pending bit, the FSM goes to EOFM instead of IDLE.
  - EOFM writes `32'h00454F46` ("EOF") if `fifo_usedw < MESSAGE_BUF_MAX-1`; otherwise it writes nothing. A skipped marker does not count toward `drop_count`.
  - EOFM then goes to IDLE.
  - After a space-drop, EOFM is entered in the same way.
  - Epoch length becomes 4k+2 cycles.
- **Not defined**: there is no EOFM state and SCAN goes directly to IDLE.

## Test plan

- **Basic epoch**: reset; `bb_found=4'b0101`, tracker0 box (10,20)-(30,40) id "RBB", tracker2 box (100,5)-(120,9) id "BBB", `fifo_usedw=0`; pulse `frame_end`.
  - Expect writes at t+2..t+4: `00524242`, `000A0014`, `001E0028`.
  - Then at t+6..t+8: `00424242`, `00640005`, `00780009`.
  - `busy` low at t+10.
- **Interval**: with `MSG_INTERVAL=6`, pulse `frame_end` 13 times.
  - Epochs start only on pulses 1, 7 and 13.
- **Round-robin carry**: `bb_found=4'b1111`, FIFO with space for exactly 2 messages.
  - First epoch sends trackers 0 and 1; `drop_count=2`.
  - Second epoch (FIFO emptied) sends in order 2, 3, 0, 1.
- **FIFO full**: `fifo_usedw=253` at SCAN with 3 pending.
  - Expect no write; `drop_count` increments by 3; `busy` low the next cycle.
- **Overlap and saturation**:
  - `MSG_INTERVAL=1`; `frame_end` every 3 cycles with 4 boxes pending. Epochs that arrive while `busy` are skipped and each skip increments `drop_count` by 1.
  - Drive `drop_count` to 255; it stays at 255.
- **Reset mid-TL**: assert `reset_n=0` for 1 cycle during TL.
  - The next cycle shows `fifo_wrreq=0`, `busy=0`, `drop_count=0`.
  - The next `frame_end` starts a new epoch with `rr_ptr=0`.
